// File: rtl/key_event_decoder.sv
// key_event_decoder: turns a debounced key level into one-cycle event pulses
// (press, release, click, double click, long press, auto-repeat) plus a held level.
module key_event_decoder #(
  parameter int ACTIVE_LEVEL = 1,
  parameter int LONG_MS      = 1000,
  parameter int REPEAT_MS    = 200,
  parameter int DCLICK_MS    = 300,
  parameter int CNT_W        = 11
) (
  input  logic clk_1KHz,
  input  logic rst,
  input  logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic dclick_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;

  // Terminal counts: a threshold of T cycles fires when the counter reads T-1.
  localparam logic [CNT_W-1:0] LONG_END   = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] REPEAT_END = CNT_W'(REPEAT_MS - 1);
  localparam logic [CNT_W-1:0] DCLICK_END = CNT_W'(DCLICK_MS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             click_q, click_d;
  logic             dclick_q, dclick_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;
  logic             pressed;

  assign pressed = (key_level == 1'(ACTIVE_LEVEL));

  // State, counter and registered outputs; reset wins over everything.
  always_ff @(posedge clk_1KHz) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      dclick_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      dclick_q  <= dclick_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  // Next state and counter; key changes take priority over timeouts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1, PRESS2: begin
        if (!pressed) begin
          state_d = (state_q == PRESS1) ? WAIT2 : IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LONG_END) begin
          state_d = LONG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT2: begin
        if (pressed) begin
          state_d = PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == DCLICK_END) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LONG: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REPEAT_END) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Event decode for the cycle after this edge; mirrors the transition priorities.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    dclick_d  = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    held_d    = (state_d == PRESS1) || (state_d == PRESS2) || (state_d == LONG);
    unique case (state_q)
      IDLE:   press_d = pressed;
      PRESS1: begin
        release_d = !pressed;
        long_d    = pressed && (cnt_q == LONG_END);
      end
      PRESS2: begin
        release_d = !pressed;
        dclick_d  = !pressed;
        long_d    = pressed && (cnt_q == LONG_END);
      end
      WAIT2: begin
        press_d = pressed;
        click_d = !pressed && (cnt_q == DCLICK_END);
      end
      LONG: begin
        release_d = !pressed;
        repeat_d  = pressed && (cnt_q == REPEAT_END);
      end
      default: ;
    endcase
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign click_pulse   = click_q;
  assign dclick_pulse  = dclick_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench: two decoders (active-high and active-low) share inverted
// stimulus; expected pulse vectors are queued per edge and popped by a monitor.
module tb_key_event_decoder;

  localparam logic [5:0] EP = 6'b100000; // press
  localparam logic [5:0] ER = 6'b010000; // release
  localparam logic [5:0] EC = 6'b001000; // click
  localparam logic [5:0] ED = 6'b000100; // dclick
  localparam logic [5:0] EL = 6'b000010; // long
  localparam logic [5:0] EX = 6'b000001; // repeat

  typedef struct {
    int         cyc;
    logic [5:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic key;
  logic key_n;
  wire  [6:0] o1;
  wire  [6:0] o0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[2][$];
  exp_t e;
  logic [5:0] vec;

  assign key_n = ~key;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_event_decoder #(.ACTIVE_LEVEL(1), .LONG_MS(20), .REPEAT_MS(5), .DCLICK_MS(8), .CNT_W(11)) dut_hi (
    .clk_1KHz(clk), .rst(rst), .key_level(key),
    .press_pulse(o1[6]), .release_pulse(o1[5]), .click_pulse(o1[4]), .dclick_pulse(o1[3]),
    .long_pulse(o1[2]), .repeat_pulse(o1[1]), .held(o1[0])
  );

  key_event_decoder #(.ACTIVE_LEVEL(0), .LONG_MS(20), .REPEAT_MS(5), .DCLICK_MS(8), .CNT_W(11)) dut_lo (
    .clk_1KHz(clk), .rst(rst), .key_level(key_n),
    .press_pulse(o0[6]), .release_pulse(o0[5]), .click_pulse(o0[4]), .dclick_pulse(o0[3]),
    .long_pulse(o0[2]), .repeat_pulse(o0[1]), .held(o0[0])
  );

  // Monitor: any nonzero pulse vector must match the queue head at this edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      vec = (d == 0) ? o1[6:1] : o0[6:1];
      while (q[d].size() > 0 && q[d][0].cyc < cyc) begin
        e = q[d].pop_front();
        total++; bad++;
        $display("FAIL missing_pulse dut%0d: edge %0d got none, required %b", d, e.cyc, e.v);
      end
      if (vec != 6'b0) begin
        total++;
        if (q[d].size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse dut%0d: edge %0d got %b, required none", d, cyc, vec);
        end else begin
          e = q[d].pop_front();
          if (e.cyc != cyc || e.v != vec) begin
            bad++;
            $display("FAIL pulse dut%0d: got %b at edge %0d, required %b at edge %0d",
                     d, vec, cyc, e.v, e.cyc);
          end
        end
      end
    end
  end

  task automatic ex(input int c, input logic [5:0] v);
    exp_t t;
    t.cyc = c;
    t.v   = v;
    q[0].push_back(t);
    q[1].push_back(t);
  endtask

  task automatic pk(input int n);
    key = 1'b1;
    repeat (n) @(negedge clk);
    key = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_rst(input string name);
    total++;
    if (o1 != 7'b0 || o0 != 7'b0) begin
      bad++;
      $display("FAIL %s: got hi=%b lo=%b, required all zero", name, o1, o0);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    key = 1'b0;
    idle(3);
    chk_rst("reset_init");
    rst = 1'b0;
    idle(2);

    // 1: short press -> click after the double-click window
    n = cyc + 1;
    ex(n, EP); ex(n + 5, ER); ex(n + 13, EC);
    pk(5); idle(20);

    // 2: double click
    n = cyc + 1;
    ex(n, EP); ex(n + 3, ER); ex(n + 7, EP); ex(n + 10, ER | ED);
    pk(3); idle(4); pk(3); idle(20);

    // 3: long press with auto-repeat
    n = cyc + 1;
    ex(n, EP); ex(n + 20, EL);
    ex(n + 25, EX); ex(n + 30, EX); ex(n + 35, EX); ex(n + 40, EX);
    ex(n + 42, ER);
    pk(42); idle(20);

    // 4a: release on the long threshold edge
    n = cyc + 1;
    ex(n, EP); ex(n + 20, ER); ex(n + 28, EC);
    pk(20); idle(20);

    // 4b: second press on the click timeout edge
    n = cyc + 1;
    ex(n, EP); ex(n + 3, ER); ex(n + 11, EP); ex(n + 13, ER | ED);
    pk(3); idle(8); pk(2); idle(20);

    // 5: reset while in LONG with key held, then fresh press sequence
    n = cyc + 1;
    ex(n, EP); ex(n + 20, EL); ex(n + 25, EX);
    ex(n + 29, EP); ex(n + 49, EL); ex(n + 54, EX); ex(n + 56, ER);
    key = 1'b1;
    idle(27);
    rst = 1'b1;
    idle(1); chk_rst("reset_long_1");
    idle(1); chk_rst("reset_long_2");
    rst = 1'b0;
    idle(27);
    key = 1'b0;
    idle(20);

    for (int d = 0; d < 2; d++) begin
      total++;
      if (q[d].size() != 0) begin
        bad++;
        $display("FAIL leftover dut%0d: got %0d pending, required 0", d, q[d].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Consumes the clean, debounced key level produced by the key debounce stage on the 1 kHz tick domain.
- Decodes it into single-cycle event pulses: press, release, single click, double click, long press and auto-repeat.
- Sits between the debouncer and the application logic (counters, mode selection, display control), so consumers never do their own edge or timing detection.

Parameters:
ACTIVE_LEVEL, 1, key_level value that means "pressed"
LONG_MS, 1000, cycles held continuously before long_pulse (1 cycle = 1 ms)
REPEAT_MS, 200, period of repeat_pulse after long_pulse while still held
DCLICK_MS, 300, max cycles after a short release in which a second press forms a double click
CNT_W, 11, counter width; must satisfy 2^CNT_W > max(LONG_MS, REPEAT_MS, DCLICK_MS)

Ports:
clk_1KHz  input  1  system clock, 1 kHz tick, all logic on rising edge
rst  input  1  synchronous reset, active-high
key_level  input  1  debounced key level, synchronous to clk_1KHz
press_pulse  output  1  one-cycle pulse on each accepted press
release_pulse  output  1  one-cycle pulse on each release
click_pulse  output  1  one-cycle pulse: single short press, no second press within DCLICK_MS
dclick_pulse  output  1  one-cycle pulse: second short press released
long_pulse  output  1  one-cycle pulse: held LONG_MS cycles
repeat_pulse  output  1  one-cycle pulse every REPEAT_MS cycles after long_pulse while held
held  output  1  level: 1 while FSM in a pressed state

Behaviour:
- Define pressed = (key_level == ACTIVE_LEVEL), sampled at each rising edge.
- All outputs are registered. A pulse decided at edge E is high for exactly the cycle after E.
- Reset:
  - When rst=1 at an edge: state=IDLE, cnt=0, all outputs 0.
  - rst overrides everything, including mid-press.
  - After reset releases, a key already pressed is treated as a fresh press at the first edge with rst=0.
- Events are never merged or dropped within a cycle; at most one event pulse per cycle, except release_pulse+dclick_pulse together.
- FSM states: IDLE, PRESS1, WAIT2, PRESS2, LONG. held=1 in PRESS1, PRESS2, LONG.
- IDLE:
  - pressed -> press_pulse, cnt<=0, go PRESS1.
  - Otherwise stay.
- PRESS1:
  - not pressed -> release_pulse, cnt<=0, go WAIT2.
  - Else if cnt==LONG_MS-1 -> long_pulse, cnt<=0, go LONG.
  - Else cnt<=cnt+1.
  - Release at the threshold edge takes priority: no long_pulse.
- LONG:
  - not pressed -> release_pulse, go IDLE. No click or dclick is ever emitted after a long press.
  - Else if cnt==REPEAT_MS-1 -> repeat_pulse, cnt<=0.
  - Else cnt<=cnt+1.
- WAIT2:
  - pressed -> press_pulse, cnt<=0, go PRESS2.
  - Else if cnt==DCLICK_MS-1 -> click_pulse, go IDLE.
  - Else cnt<=cnt+1.
  - A press at the timeout edge takes priority: becomes the second press, no click_pulse.
- PRESS2:
  - not pressed -> release_pulse and dclick_pulse in the same cycle, go IDLE.
  - Else if cnt==LONG_MS-1 -> long_pulse, cnt<=0, go LONG. The first click is discarded.
  - Else cnt<=cnt+1.
- Timing, with press_pulse driven after edge N and the key held:
  - long_pulse follows edge N+LONG_MS.
  - repeat_pulse follows edges N+LONG_MS+k*REPEAT_MS, k>=1.
- Counter never exceeds max threshold-1; no wrap occurs.
- No triple-click: a third press after dclick starts a new sequence from IDLE.

Test Plan:
Use LONG_MS=20, REPEAT_MS=5, DCLICK_MS=8 for simulation.
1. Press 5 cycles, release, idle 20 -> press_pulse, release_pulse 5 cycles later, click_pulse 8 cycles after release_pulse; no dclick, long or repeat.
2. Press 3, release 4, press 3, release -> two press_pulses, one cycle with release_pulse=dclick_pulse=1; click_pulse never asserted.
3. Hold 42 cycles, release -> long_pulse 20 cycles after press_pulse, repeat_pulse at +25, +30, +35, +40; release_pulse on release; no click.
4. Boundaries:
   - Release exactly at cycle 20 of a hold -> release_pulse, no long_pulse.
   - Second press exactly at WAIT2 timeout edge -> press_pulse, no click_pulse.
5. Assert rst for 2 cycles during LONG with key held, then deassert -> all outputs 0 during reset; press_pulse the cycle after the first edge with rst=0; repeat count restarts (long_pulse 20 cycles later).
6. ACTIVE_LEVEL=0, repeat scenario 1 with inverted key_level -> identical pulse sequence and timing.
